pwm_ramp_ctrl: RTL



---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_ramp_ctrl_if.sv | 15 +
 rtl/pwm_period_tick.sv | 35 +++
 rtl/pwm_ramp_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the PWM duty ramp controller.
//   ramp_state_e : ramp sequencer states
//   DUTY_W       : width of every duty / cycle-count value
//   clamp_duty   : limits a requested duty to the PWM period length
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    SETTLED = 2'd2
  } ramp_state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] req,
                                                   input logic [DUTY_W-1:0] max_duty);
    return (req > max_duty) ? max_duty : req;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: target-duty command channel (valid/ready).
//   cmd_valid : new target duty offered        (master -> slave)
//   cmd_duty  : requested target duty, clk cycles (master -> slave)
//   cmd_ready : slave can take a command        (slave -> master)
interface pwm_ramp_ctrl_if;
  import pwm_pkg::*;

  logic              cmd_valid;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/pwm_period_tick.sv
// pwm_period_tick: PWM period counter kept in lock-step with the generator.
//   clk      : system clock
//   reset    : asynchronous, active-low reset (counter restarts at 1)
//   tick     : high in the last cycle of each period (cnt == period)
//   pre_tick : high one cycle before tick (cnt == period - 1)
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int G_PWM_PERIOD_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic pre_tick
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(G_PWM_PERIOD_CYCLES);
  localparam logic [DUTY_W-1:0] CNT_PRE  = DUTY_W'(G_PWM_PERIOD_CYCLES - 1);

  logic [DUTY_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= DUTY_W'(1);
    end else if (cnt == CNT_LAST) begin
      cnt <= DUTY_W'(1);
    end else begin
      cnt <= cnt + DUTY_W'(1);
    end
  end

  assign tick     = (cnt == CNT_LAST);
  assign pre_tick = (cnt == CNT_PRE);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start / soft-stop duty ramp sequencer for a PWM generator.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   enable     : 1 = run; 0 = target forced to 0 (ramp down)
//   cmd        : target duty command channel (slave side)
//   pwm_duty   : duty presented to the generator, changes only on pre_tick edges
//   pwm_update : one-cycle strobe in the tick cycle when pwm_duty changed
//   busy       : ramp in progress
//   at_target  : pwm_duty equals the current target
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int G_PWM_PERIOD_CYCLES = 1000,
  parameter int STEP                = 16,
  parameter int STEP_PERIODS        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pwm_ramp_ctrl_if.slave       cmd,
  output logic [DUTY_W-1:0]    pwm_duty,
  output logic                 pwm_update,
  output logic                 busy,
  output logic                 at_target
);

  localparam logic [DUTY_W-1:0] PERIOD_MAX = DUTY_W'(G_PWM_PERIOD_CYCLES);
  localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] SP_LAST    = DUTY_W'(STEP_PERIODS - 1);

  // One ramp step from cur toward tgt; the upward sum is one bit wider so it never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] diff;
    sum  = {1'b0, cur} + STEP_X;
    diff = {1'b0, cur} - {1'b0, tgt};
    if (tgt > cur) begin
      return (sum >= {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
    end else if (diff <= STEP_X) begin
      return tgt;
    end else begin
      return cur - STEP_X[DUTY_W-1:0];
    end
  endfunction

  ramp_state_e       state;
  ramp_state_e       state_nxt;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] step_cnt;
  logic [DUTY_W-1:0] duty_step;
  logic [DUTY_W-1:0] duty_nxt;
  logic              upd_nxt;
  logic              tick;
  logic              pre_tick;
  logic              step_due;
  logic              accept;

  pwm_period_tick #(
    .G_PWM_PERIOD_CYCLES(G_PWM_PERIOD_CYCLES)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Period pacing: step_cnt counts ticks; a step lands on the pre_tick edge of
  // every STEP_PERIODS-th period so the generator latches it on its period pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
    end else if (tick) begin
      step_cnt <= (step_cnt == SP_LAST) ? '0 : step_cnt + DUTY_W'(1);
    end
  end

  assign step_due = pre_tick && (step_cnt == SP_LAST);

  // Command intake: retargeting only outside a ramp; enable low pins target to 0.
  assign cmd.cmd_ready = (state != RAMP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready && enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target <= '0;
    end else if (!enable) begin
      target <= '0;
    end else if (accept) begin
      target <= clamp_duty(cmd.cmd_duty, PERIOD_MAX);
    end
  end

  // Ramp FSM: next state and next duty.
  always_comb begin
    state_nxt = state;
    duty_nxt  = pwm_duty;
    upd_nxt   = 1'b0;
    duty_step = step_toward(pwm_duty, target);
    unique case (state)
      IDLE: begin
        if (target != pwm_duty) state_nxt = RAMP;
      end
      RAMP: begin
        if (step_due) begin
          duty_nxt = duty_step;
          upd_nxt  = (duty_step != pwm_duty);
          if (duty_step == target) state_nxt = (target == '0) ? IDLE : SETTLED;
        end
      end
      SETTLED: begin
        if (target != pwm_duty)  state_nxt = RAMP;
        else if (target == '0)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register stage: duty and strobe change only on step_due edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pwm_duty   <= '0;
      pwm_update <= 1'b0;
    end else begin
      state      <= state_nxt;
      pwm_duty   <= duty_nxt;
      pwm_update <= upd_nxt;
    end
  end

  assign busy      = (state == RAMP);
  assign at_target = (pwm_duty == target);

endmodule
